// File: rtl/dff_pipe_pkg.sv
// Shared definitions for the dff_pipe delay line: default sizing, count-width helper and
// the stage word layout.
package dff_pipe_pkg;

  localparam int unsigned DefaultWidth = 8;
  localparam int unsigned DefaultDepth = 3;

  // Stage word at the default width; the pipe itself carries valid and data side by side.
  typedef struct packed {
    logic                    valid;
    logic [DefaultWidth-1:0] data;
  } stage_t;

  // Ceiling log2, usable in constant expressions such as port widths.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dff_stage.sv
// One WIDTH+1-bit pipe stage: synchronous active-low reset, flush clears valid only,
// enable gates the capture of {valid, data}.
module dff_stage import dff_pipe_pkg::*; #(
  parameter int unsigned       Width    = DefaultWidth,
  parameter logic [Width-1:0]  ResetVal = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             flush_i,
  input  logic             valid_i,
  input  logic [Width-1:0] data_i,
  output logic             valid_o,
  output logic [Width-1:0] data_o
);

  logic             valid_d, valid_q;
  logic [Width-1:0] data_d, data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (en_i) begin
      valid_d = valid_i;
      data_d  = data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= ResetVal;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/dff_pipe.sv
// DEPTH-stage, WIDTH-bit registered delay line with stall, per-stage valid, flush and an
// occupancy count. Define DFF_PIPE_QBAR_EN to add the inverted output q_bar.
module dff_pipe import dff_pipe_pkg::*; #(
  parameter int unsigned      WIDTH     = DefaultWidth,
  parameter int unsigned      DEPTH     = DefaultDepth,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          en,
  input  logic                          flush,
  input  logic [WIDTH-1:0]              d,
  input  logic                          d_valid,
  output logic [WIDTH-1:0]              q,
  output logic                          q_valid,
  output logic [clog2(DEPTH+1)-1:0]     count
`ifdef DFF_PIPE_QBAR_EN
  ,
  output logic [WIDTH-1:0]              q_bar
`endif
);

  localparam int unsigned CntW = clog2(DEPTH + 1);

  logic [WIDTH-1:0] stage_data  [DEPTH];
  logic             stage_valid [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] data_in;
    logic             valid_in;

    if (i == 0) begin : g_head
      assign data_in  = d;
      assign valid_in = d_valid;
    end else begin : g_body
      assign data_in  = stage_data[i-1];
      assign valid_in = stage_valid[i-1];
    end

    dff_stage #(
      .Width   (WIDTH),
      .ResetVal(RESET_VAL)
    ) u_stage (
      .clk_i  (clk),
      .rst_ni (rstn),
      .en_i   (en),
      .flush_i(flush),
      .valid_i(valid_in),
      .data_i (data_in),
      .valid_o(stage_valid[i]),
      .data_o (stage_data[i])
    );
  end

  logic [CntW-1:0] count_d, count_q;

  // One word in, one word out per shift: the count never leaves 0..DEPTH.
  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + CntW'(d_valid) - CntW'(stage_valid[DEPTH-1]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign q       = stage_data[DEPTH-1];
  assign q_valid = stage_valid[DEPTH-1];
  assign count   = count_q;

`ifdef DFF_PIPE_QBAR_EN
  assign q_bar = ~q;
`endif

endmodule

// File: tb/tb_dff_pipe.sv
// Directed bench for dff_pipe at WIDTH=8, DEPTH=3, RESET_VAL=0: reset, latency, stall,
// flush, mixed valid and mid-stream reset.
module tb_dff_pipe;

  logic       clk;
  logic       rstn;
  logic       en;
  logic       flush;
  logic [7:0] d;
  logic       d_valid;
  logic [7:0] q;
  logic       q_valid;
  logic [1:0] count;
`ifdef DFF_PIPE_QBAR_EN
  logic [7:0] q_bar;
`endif

  int n_total;
  int n_pass;

  dff_pipe #(
    .WIDTH    (8),
    .DEPTH    (3),
    .RESET_VAL(8'h00)
  ) dut (
    .clk    (clk),
    .rstn   (rstn),
    .en     (en),
    .flush  (flush),
    .d      (d),
    .d_valid(d_valid),
    .q      (q),
    .q_valid(q_valid),
    .count  (count)
`ifdef DFF_PIPE_QBAR_EN
    ,
    .q_bar  (q_bar)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply inputs, take one rising edge, then settle before sampling.
  task automatic step(input logic r, input logic e, input logic f, input logic [7:0] dd,
                      input logic dv);
    rstn    = r;
    en      = e;
    flush   = f;
    d       = dd;
    d_valid = dv;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    step(1'b0, 1'b1, 1'b0, 8'hFF, 1'b1);
    step(1'b0, 1'b1, 1'b0, 8'hFF, 1'b1);
    n_total++;
    if (q !== 8'h00) $display("FAIL reset_q: got %h want 00", q);
    else n_pass++;
    n_total++;
    if (q_valid !== 1'b0) $display("FAIL reset_qv: got %b want 0", q_valid);
    else n_pass++;
    n_total++;
    if (count !== 2'd0) $display("FAIL reset_count: got %0d want 0", count);
    else n_pass++;
`ifdef DFF_PIPE_QBAR_EN
    n_total++;
    if (q_bar !== 8'hFF) $display("FAIL reset_qbar: got %h want FF", q_bar);
    else n_pass++;
`endif
    rstn = 1'b1;
  endtask

  task automatic test_latency();
    logic [7:0] din [6] = '{8'hA5, 8'h3C, 8'h7E, 8'h00, 8'h00, 8'h00};
    logic       dv  [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [7:0] eq  [6] = '{8'h00, 8'h00, 8'hA5, 8'h3C, 8'h7E, 8'h00};
    logic       ev  [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [1:0] ec  [6] = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, 1'b0, din[i], dv[i]);
      n_total++;
      if (q !== eq[i]) $display("FAIL latency_q[%0d]: got %h want %h", i, q, eq[i]);
      else n_pass++;
      n_total++;
      if (q_valid !== ev[i]) $display("FAIL latency_qv[%0d]: got %b want %b", i, q_valid, ev[i]);
      else n_pass++;
      n_total++;
      if (count !== ec[i]) $display("FAIL latency_count[%0d]: got %0d want %0d", i, count, ec[i]);
      else n_pass++;
`ifdef DFF_PIPE_QBAR_EN
      n_total++;
      if (q_bar !== ~eq[i]) $display("FAIL latency_qbar[%0d]: got %h want %h", i, q_bar, ~eq[i]);
      else n_pass++;
`endif
    end
  endtask

  task automatic test_stall();
    // A5 enters, two stalled edges with new d offered, then three shifting edges.
    logic       e   [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [7:0] din [6] = '{8'hA5, 8'h55, 8'h66, 8'h00, 8'h00, 8'h00};
    logic       dv  [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [7:0] eq  [6] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hA5, 8'h00};
    logic       ev  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [1:0] ec  [6] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1'b1, e[i], 1'b0, din[i], dv[i]);
      n_total++;
      if (q !== eq[i]) $display("FAIL stall_q[%0d]: got %h want %h", i, q, eq[i]);
      else n_pass++;
      n_total++;
      if (q_valid !== ev[i]) $display("FAIL stall_qv[%0d]: got %b want %b", i, q_valid, ev[i]);
      else n_pass++;
      n_total++;
      if (count !== ec[i]) $display("FAIL stall_count[%0d]: got %0d want %0d", i, count, ec[i]);
      else n_pass++;
    end
  endtask

  task automatic test_flush();
    logic [7:0] eq [3] = '{8'h22, 8'h23, 8'h00};
    do_reset();
    step(1'b1, 1'b1, 1'b0, 8'h21, 1'b1);
    step(1'b1, 1'b1, 1'b0, 8'h22, 1'b1);
    step(1'b1, 1'b1, 1'b0, 8'h23, 1'b1);
    n_total++;
    if (count !== 2'd3) $display("FAIL flush_full_count: got %0d want 3", count);
    else n_pass++;
    step(1'b1, 1'b1, 1'b1, 8'h11, 1'b1);
    n_total++;
    if (count !== 2'd0) $display("FAIL flush_count: got %0d want 0", count);
    else n_pass++;
    n_total++;
    if (q_valid !== 1'b0) $display("FAIL flush_qv: got %b want 0", q_valid);
    else n_pass++;
    n_total++;
    if (q !== 8'h21) $display("FAIL flush_q_held: got %h want 21", q);
    else n_pass++;
    // Drain: stale data shifts out invalid and 11 never appears.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
      n_total++;
      if (q !== eq[i]) $display("FAIL flush_drain_q[%0d]: got %h want %h", i, q, eq[i]);
      else n_pass++;
      n_total++;
      if (q_valid !== 1'b0) $display("FAIL flush_drain_qv[%0d]: got %b want 0", i, q_valid);
      else n_pass++;
      n_total++;
      if (count !== 2'd0) $display("FAIL flush_drain_count[%0d]: got %0d want 0", i, count);
      else n_pass++;
    end
  endtask

  task automatic test_mixed_valid();
    logic [7:0] din [7] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h00, 8'h00};
    logic       dv  [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [7:0] eq  [7] = '{8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00};
    logic       ev  [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [1:0] ec  [7] = '{2'd1, 2'd1, 2'd2, 2'd1, 2'd1, 2'd0, 2'd0};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 1'b1, 1'b0, din[i], dv[i]);
      n_total++;
      if (q !== eq[i]) $display("FAIL mixed_q[%0d]: got %h want %h", i, q, eq[i]);
      else n_pass++;
      n_total++;
      if (q_valid !== ev[i]) $display("FAIL mixed_qv[%0d]: got %b want %b", i, q_valid, ev[i]);
      else n_pass++;
      n_total++;
      if (count !== ec[i]) $display("FAIL mixed_count[%0d]: got %0d want %0d", i, count, ec[i]);
      else n_pass++;
    end
  endtask

  task automatic test_midstream_reset();
    logic [7:0] eq [3] = '{8'h00, 8'h00, 8'h44};
    logic       ev [3] = '{1'b0, 1'b0, 1'b1};
    do_reset();
    step(1'b1, 1'b1, 1'b0, 8'h31, 1'b1);
    step(1'b1, 1'b1, 1'b0, 8'h32, 1'b1);
    n_total++;
    if (count !== 2'd2) $display("FAIL midrst_inflight_count: got %0d want 2", count);
    else n_pass++;
    step(1'b0, 1'b1, 1'b0, 8'h33, 1'b1);
    n_total++;
    if (q !== 8'h00) $display("FAIL midrst_q: got %h want 00", q);
    else n_pass++;
    n_total++;
    if (q_valid !== 1'b0) $display("FAIL midrst_qv: got %b want 0", q_valid);
    else n_pass++;
    n_total++;
    if (count !== 2'd0) $display("FAIL midrst_count: got %0d want 0", count);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      if (i == 0) step(1'b1, 1'b1, 1'b0, 8'h44, 1'b1);
      else step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
      n_total++;
      if (q !== eq[i]) $display("FAIL midrst_after_q[%0d]: got %h want %h", i, q, eq[i]);
      else n_pass++;
      n_total++;
      if (q_valid !== ev[i]) $display("FAIL midrst_after_qv[%0d]: got %b want %b", i, q_valid, ev[i]);
      else n_pass++;
      n_total++;
      if (count !== 2'd1) $display("FAIL midrst_after_count[%0d]: got %0d want 1", i, count);
      else n_pass++;
    end
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    rstn    = 1'b0;
    en      = 1'b0;
    flush   = 1'b0;
    d       = 8'h00;
    d_valid = 1'b0;
    test_reset();
    test_latency();
    test_stall();
    test_flush();
    test_mixed_valid();
    test_midstream_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
